// File: rtl/reg_file_pkg.sv
/*------------------------------------------------------------------------------
 * Module : reg_file_pkg
 * Shared widths and write-bus field positions for the RV32I register file.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package reg_file_pkg;
   localparam int RF_ADDR_WD     = 5;
   localparam int RF_DATA_WD     = 32;
   localparam int RF_NUM_REGS    = 32;
   localparam int W_TO_RF_BUS_WD = 1 + RF_ADDR_WD + RF_DATA_WD;

   // Field positions on w_to_rf_bus, shared with the write-back stage
   localparam int RF_WE_BIT  = 37;
   localparam int RF_WADDR_HI = 36;
   localparam int RF_WADDR_LO = 32;
   localparam int RF_WDATA_HI = 31;
   localparam int RF_WDATA_LO = 0;
endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
/*------------------------------------------------------------------------------
 * Module : rf_read_port
 * Combinational read mux: x0 forced to zero, optional forwarded value.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module rf_read_port #(
   parameter int ADDR_WD = 5,
   parameter int DATA_WD = 32
) (
   input  logic [ADDR_WD-1:0] raddr,
   input  logic [DATA_WD-1:0] stored,
   input  logic               fwd_en,
   input  logic [DATA_WD-1:0] fwd_data,
   output logic [DATA_WD-1:0] rdata
);

   always_comb begin
      rdata = stored;
      if (raddr == '0) begin
         rdata = '0;
      end else if (fwd_en) begin
         rdata = fwd_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
/*------------------------------------------------------------------------------
 * Module : reg_file
 * RV32I register file: 1 write, 2 async reads, committed-write counter.
 * Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module reg_file
   import reg_file_pkg::*;
#(
   parameter int ADDR_WD  = RF_ADDR_WD,
   parameter int DATA_WD  = RF_DATA_WD,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [W_TO_RF_BUS_WD-1:0] w_to_rf_bus,
   input  logic [ADDR_WD-1:0]        raddr1,
   input  logic [ADDR_WD-1:0]        raddr2,
   output logic [DATA_WD-1:0]        rdata1,
   output logic [DATA_WD-1:0]        rdata2,
   output logic [31:0]               rf_write_count
);

   logic               we;
   logic [ADDR_WD-1:0] waddr;
   logic [DATA_WD-1:0] wdata;
   logic               commit;

   logic [DATA_WD-1:0] regs_q [NUM_REGS];
   logic [DATA_WD-1:0] regs_d [NUM_REGS];
   logic [31:0]        rf_write_count_q;
   logic [31:0]        rf_write_count_d;

   assign we     = w_to_rf_bus[RF_WE_BIT];
   assign waddr  = w_to_rf_bus[RF_WADDR_HI:RF_WADDR_LO];
   assign wdata  = w_to_rf_bus[RF_WDATA_HI:RF_WDATA_LO];
   assign commit = we && (waddr != '0) && !reset;

   always_comb begin
      regs_d = regs_q;
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = '0;
         end
      end else if (commit) begin
         regs_d[waddr] = wdata;
      end
      regs_d[0] = '0;
   end

   always_comb begin
      rf_write_count_d = rf_write_count_q;
      if (reset) begin
         rf_write_count_d = '0;
      end else if (commit) begin
         rf_write_count_d = rf_write_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      regs_q           <= regs_d;
      rf_write_count_q <= rf_write_count_d;
   end

   assign rf_write_count = rf_write_count_q;

   logic [ADDR_WD-1:0] rd_addr [2];
   logic [DATA_WD-1:0] rd_data [2];
   logic               fwd_en  [2];

   assign rd_addr[0] = raddr1;
   assign rd_addr[1] = raddr2;

   generate
      for (genvar p = 0; p < 2; p++) begin : g_rd_port
`ifdef REGFILE_BYPASS_EN
         // commit already excludes reset and x0, so no forwarding in those cases
         assign fwd_en[p] = commit && (waddr == rd_addr[p]);
`else
         assign fwd_en[p] = 1'b0;
`endif
         rf_read_port #(
            .ADDR_WD (ADDR_WD),
            .DATA_WD (DATA_WD)
         ) u_rd_port (
            .raddr    (rd_addr[p]),
            .stored   (regs_q[rd_addr[p]]),
            .fwd_en   (fwd_en[p]),
            .fwd_data (wdata),
            .rdata    (rd_data[p])
         );
      end
   endgenerate

   assign rdata1 = rd_data[0];
   assign rdata2 = rd_data[1];

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
/*------------------------------------------------------------------------------
 * Module : tb_reg_file
 * Directed self-checking bench for reg_file (honours REGFILE_BYPASS_EN).
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_reg_file;
   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] w_to_rf_bus;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2, rf_write_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reg_file dut (
      .clk            (clk),
      .reset          (reset),
      .w_to_rf_bus    (w_to_rf_bus),
      .raddr1         (raddr1),
      .raddr2         (raddr2),
      .rdata1         (rdata1),
      .rdata2         (rdata2),
      .rf_write_count (rf_write_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [37:0] bus(input logic we, input logic [4:0] a, input logic [31:0] d);
      return {we, a, d};
   endfunction

   // Inputs change on the falling edge; checks sample 1 time unit later
   task automatic drive(input logic rst, input logic [37:0] b,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      reset       = rst;
      w_to_rf_bus = b;
      raddr1      = a1;
      raddr2      = a2;
      #1;
   endtask

   logic [31:0] alt_val;
   logic [31:0] prev_val;
   logic [31:0] exp_same;

   initial begin
      reset = 1'b1; w_to_rf_bus = '0; raddr1 = '0; raddr2 = '0;
      repeat (2) @(posedge clk);

      // Reset state: every index zero on both ports
      drive(1'b0, '0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(31 - i);
         #1;
         check($sformatf("rst_rd1_x%0d", i), rdata1, 32'h0);
         check($sformatf("rst_rd2_x%0d", 31 - i), rdata2, 32'h0);
      end
      check("rst_count", rf_write_count, 32'd0);

      // Write x5, read back next cycle
      drive(1'b0, bus(1'b1, 5'd5, 32'hDEAD_BEEF), 5'd0, 5'd0);
      drive(1'b0, '0, 5'd5, 5'd5);
      check("x5_rd1", rdata1, 32'hDEAD_BEEF);
      check("x5_rd2", rdata2, 32'hDEAD_BEEF);
      check("x5_count", rf_write_count, 32'd1);

      // Write to x0 is discarded, including the same-cycle read
      drive(1'b0, bus(1'b1, 5'd0, 32'h1234_5678), 5'd0, 5'd5);
      check("x0_same_cycle", rdata1, 32'h0);
      drive(1'b0, '0, 5'd0, 5'd5);
      check("x0_rd", rdata1, 32'h0);
      check("x0_x5_intact", rdata2, 32'hDEAD_BEEF);
      check("x0_count", rf_write_count, 32'd1);

      // Same-cycle read of the register being written
      drive(1'b0, bus(1'b1, 5'd7, 32'hA5A5_A5A5), 5'd5, 5'd7);
`ifdef REGFILE_BYPASS_EN
      check("x7_same_cycle", rdata2, 32'hA5A5_A5A5);
`else
      check("x7_same_cycle", rdata2, 32'h0);
`endif
      check("x7_other_port", rdata1, 32'hDEAD_BEEF);
      drive(1'b0, '0, 5'd7, 5'd7);
      check("x7_next_rd1", rdata1, 32'hA5A5_A5A5);
      check("x7_next_rd2", rdata2, 32'hA5A5_A5A5);
      check("x7_count", rf_write_count, 32'd2);

      // Write during reset is dropped, and no forwarding occurs
      drive(1'b1, bus(1'b1, 5'd3, 32'd1), 5'd3, 5'd5);
      check("rst_wr_no_fwd", rdata1, 32'h0);
      drive(1'b0, '0, 5'd3, 5'd5);
      check("rst_wr_x3", rdata1, 32'h0);
      check("rst_wr_x5", rdata2, 32'h0);
      check("rst_wr_count", rf_write_count, 32'd0);
      drive(1'b0, bus(1'b1, 5'd3, 32'd2), 5'd3, 5'd7);
      drive(1'b0, '0, 5'd3, 5'd7);
      check("x3_rd", rdata1, 32'd2);
      check("x7_cleared", rdata2, 32'h0);
      check("x3_count", rf_write_count, 32'd1);

      // Counter wrap: preload to all-ones, then one committed write
      @(negedge clk);
      force dut.rf_write_count_d = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.rf_write_count_d;
      #1;
      check("wrap_preload", rf_write_count, 32'hFFFF_FFFF);
      drive(1'b0, bus(1'b1, 5'd9, 32'h0000_0099), 5'd9, 5'd0);
      drive(1'b0, '0, 5'd9, 5'd0);
      check("wrap_x9", rdata1, 32'h0000_0099);
      check("wrap_count", rf_write_count, 32'd0);

      // Back-to-back writes to x31 with alternating data
      prev_val = 32'h0;
      for (int k = 0; k < 4; k++) begin
         alt_val = k[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
         drive(1'b0, bus(1'b1, 5'd31, alt_val), 5'd31, 5'd31);
`ifdef REGFILE_BYPASS_EN
         exp_same = alt_val;
`else
         exp_same = prev_val;
`endif
         check($sformatf("x31_b2b_%0d", k), rdata1, exp_same);
         check($sformatf("x31_cnt_%0d", k), rf_write_count, 32'(k));
         prev_val = alt_val;
      end
      drive(1'b0, '0, 5'd31, 5'd31);
      check("x31_final", rdata2, 32'hAAAA_AAAA);
      check("x31_count", rf_write_count, 32'd4);

      // Mid-stream reset clears everything at the next edge
      drive(1'b1, bus(1'b1, 5'd31, 32'h1111_1111), 5'd31, 5'd9);
      drive(1'b0, '0, 5'd31, 5'd9);
      check("mid_rst_x31", rdata1, 32'h0);
      check("mid_rst_x9", rdata2, 32'h0);
      check("mid_rst_count", rf_write_count, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule

`default_nettype wire
